// File: rtl/ptp_rx_parser_pkg.sv
// Shared constants for the PTP receive parser: word header codes, PTP message
// types, the ptp_rx_type codes seen by PTP control, and field bit positions.
package ptp_rx_parser_pkg;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_MID  = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  localparam logic [7:0] MSG_SYNC  = 8'h01;
  localparam logic [7:0] MSG_DREQ  = 8'h03;
  localparam logic [7:0] MSG_DRESP = 8'h04;
  localparam logic [7:0] MSG_TEST  = 8'h05;

  // Same codes the transmit processor uses for ptp_tx_type.
  localparam logic [3:0] RX_TYPE_SYNC  = 4'd1;
  localparam logic [3:0] RX_TYPE_DREQ  = 4'd3;
  localparam logic [3:0] RX_TYPE_DRESP = 4'd4;
  localparam logic [3:0] RX_TYPE_TEST  = 4'd5;

  localparam int HDR_MSB   = 133;
  localparam int HDR_LSB   = 132;
  localparam int PORT_MSB  = 125;
  localparam int PORT_LSB  = 120;
  localparam int TS_MSB    = 47;
  localparam int TS_LSB    = 0;
  localparam int DMAC_MSB  = 127;
  localparam int DMAC_LSB  = 80;
  localparam int SMAC_MSB  = 79;
  localparam int SMAC_LSB  = 32;
  localparam int ETYPE_MSB = 31;
  localparam int ETYPE_LSB = 16;
  localparam int MSGT_MSB  = 15;
  localparam int MSGT_LSB  = 8;
  localparam int VER_MSB   = 7;
  localparam int VER_LSB   = 0;
  localparam int TAIL_MSB  = 95;
  localparam int TAIL_LSB  = 48;

  function automatic logic msg_supported(input logic [7:0] msg);
    return (msg == MSG_SYNC) || (msg == MSG_DREQ) || (msg == MSG_DRESP) || (msg == MSG_TEST);
  endfunction

  function automatic logic [3:0] msg_to_rx_type(input logic [7:0] msg);
    case (msg)
      MSG_SYNC:  return RX_TYPE_SYNC;
      MSG_DREQ:  return RX_TYPE_DREQ;
      MSG_DRESP: return RX_TYPE_DRESP;
      MSG_TEST:  return RX_TYPE_TEST;
      default:   return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ptp_rx_parser_field_latch.sv
// Capture registers for the per-frame fields: head port/timestamp, w2 SMAC and
// message type, and the tail field (with a same-cycle bypass for direct accept).
module ptp_rx_field_latch
  import ptp_rx_parser_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap_head,
  input  logic        cap_w2,
  input  logic        cap_tail,
  input  logic [5:0]  in_port,
  input  logic [47:0] in_ts,
  input  logic [47:0] in_smac,
  input  logic [7:0]  in_msg,
  input  logic [47:0] in_tail,
  output logic [5:0]  port,
  output logic [47:0] ts,
  output logic [47:0] smac,
  output logic [7:0]  msg_type,
  output logic [47:0] tail_field
);

  logic [5:0]  port_q, port_d;
  logic [47:0] ts_q, ts_d;
  logic [47:0] smac_q, smac_d;
  logic [7:0]  msg_q, msg_d;
  logic [47:0] tail_q, tail_d;

  always_comb begin
    port_d = port_q;
    ts_d   = ts_q;
    smac_d = smac_q;
    msg_d  = msg_q;
    tail_d = tail_q;
    if (cap_head) begin
      port_d = in_port;
      ts_d   = in_ts;
    end
    if (cap_w2) begin
      smac_d = in_smac;
      msg_d  = in_msg;
    end
    if (cap_tail) tail_d = in_tail;
  end

  // NOTE: these are plain registers, not a RAM, so resetting them is cheap and
  // keeps every downstream output deterministic straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q <= '0;
      ts_q   <= '0;
      smac_q <= '0;
      msg_q  <= '0;
      tail_q <= '0;
    end else begin
      port_q <= port_d;
      ts_q   <= ts_d;
      smac_q <= smac_d;
      msg_q  <= msg_d;
      tail_q <= tail_d;
    end
  end

  assign port       = port_q;
  assign ts         = ts_q;
  assign smac       = smac_q;
  assign msg_type   = msg_q;
  assign tail_field = cap_tail ? in_tail : tail_q;

endmodule

// File: rtl/ptp_rx_parser.sv
// PTP receive parser: validates EtherType 0x88F7 frames from the MAC rx stream,
// emits sync / delay-request / delay-response pulses and counts accepts and drops.
module ptp_rx_parser
  import ptp_rx_parser_pkg::*;
#(
  parameter logic [15:0] PTP_ETYPE = 16'h88F7,
  parameter logic [7:0]  PTP_VER   = 8'h01,
  parameter int          PKT_WORDS = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_data_wr,
  input  logic [133:0] in_data,
  input  logic         in_valid_wr,
  input  logic         in_valid,
  input  logic [47:0]  MAC_ADDR,
  output logic [53:0]  key,
  output logic         key_valid,
  output logic [47:0]  ts_4,
  output logic         ts_4_valid,
  output logic [47:0]  sync_t1,
  output logic [47:0]  sync_t2,
  output logic         sync_valid,
  output logic [47:0]  dresp_t4,
  output logic         dresp_valid,
  output logic [3:0]   ptp_rx_type,
  output logic         ptp_rx_type_valid,
  output logic [31:0]  rx_ptp_cnt,
  output logic [31:0]  rx_drop_cnt
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HDR      = 3'd1;
  localparam logic [2:0] ST_BODY     = 3'd2;
  localparam logic [2:0] ST_WAIT_VLD = 3'd3;
  localparam logic [2:0] ST_DROP     = 3'd4;
  localparam logic [2:0] LAST_W      = 3'(PKT_WORDS - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  w_q, w_d;            // index of the word expected next
  logic        seen_tail_q, seen_tail_d;
  logic [31:0] ptp_cnt_q, ptp_cnt_d, drop_cnt_q, drop_cnt_d;
  logic        accept, drop;

  logic [53:0] key_q, key_d;
  logic [47:0] ts4_q, ts4_d, t1_q, t1_d, t2_q, t2_d, t4_q, t4_d;
  logic [3:0]  type_q, type_d;
  logic        key_vld_q, key_vld_d, sync_vld_q, sync_vld_d;
  logic        dresp_vld_q, dresp_vld_d, type_vld_q, type_vld_d;

  logic        is_head, is_tail, hdr_ok, cap_w2, cap_tail;
  logic [47:0] w2_dmac;
  logic [5:0]  lat_port;
  logic [47:0] lat_ts, lat_smac, lat_tail;
  logic [7:0]  lat_msg;
  logic        unused_vbytes;

  assign unused_vbytes = ^in_data[131:128];
  assign is_head = in_data_wr && (in_data[HDR_MSB:HDR_LSB] == HDR_HEAD);
  assign is_tail = in_data_wr && (in_data[HDR_MSB:HDR_LSB] == HDR_TAIL);
  assign w2_dmac = in_data[DMAC_MSB:DMAC_LSB];
  assign hdr_ok  = (in_data[ETYPE_MSB:ETYPE_LSB] == PTP_ETYPE)
                && (in_data[VER_MSB:VER_LSB] == PTP_VER)
                && ((w2_dmac == '1) || (w2_dmac == MAC_ADDR))
                && msg_supported(in_data[MSGT_MSB:MSGT_LSB]);
  assign cap_w2   = (state_q == ST_HDR) && in_data_wr && !is_head && (w_q == 3'd2);
  assign cap_tail = (state_q == ST_BODY) && is_tail && (w_q == LAST_W);

  ptp_rx_field_latch u_latch (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_head   (is_head),
    .cap_w2     (cap_w2),
    .cap_tail   (cap_tail),
    .in_port    (in_data[PORT_MSB:PORT_LSB]),
    .in_ts      (in_data[TS_MSB:TS_LSB]),
    .in_smac    (in_data[SMAC_MSB:SMAC_LSB]),
    .in_msg     (in_data[MSGT_MSB:MSGT_LSB]),
    .in_tail    (in_data[TAIL_MSB:TAIL_LSB]),
    .port       (lat_port),
    .ts         (lat_ts),
    .smac       (lat_smac),
    .msg_type   (lat_msg),
    .tail_field (lat_tail)
  );

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    seen_tail_d = seen_tail_q;
    w_d         = (in_data_wr && w_q != 3'd7) ? w_q + 3'd1 : w_q;
    accept      = 1'b0;
    drop        = 1'b0;
    if (is_head) begin
      // The previous frame's status may land in the same cycle as this head.
      if (state_q == ST_WAIT_VLD && in_valid_wr) begin
        accept = in_valid;
        drop   = !in_valid;
      end else if (state_q != ST_IDLE) begin
        drop = 1'b1;
      end
      state_d     = ST_HDR;
      w_d         = 3'd1;
      seen_tail_d = 1'b0;
    end else begin
      case (state_q)
        ST_HDR: begin
          if (is_tail) begin
            drop    = 1'b1;
            state_d = ST_IDLE;
          end else if (in_data_wr && w_q == 3'd2) begin
            state_d = hdr_ok ? ST_BODY : ST_DROP;
          end
        end
        ST_BODY: begin
          if (is_tail) begin
            if (w_q != LAST_W) begin
              drop    = 1'b1;
              state_d = ST_IDLE;
            end else if (in_valid_wr) begin
              accept  = in_valid;
              drop    = !in_valid;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_WAIT_VLD;
            end
          end
        end
        ST_WAIT_VLD: begin
          if (in_valid_wr) begin
            accept  = in_valid;
            drop    = !in_valid;
            state_d = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (is_tail) seen_tail_d = 1'b1;
          if ((is_tail || seen_tail_q) && in_valid_wr) begin
            drop    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
    ptp_cnt_d  = ptp_cnt_q + {31'd0, accept};
    drop_cnt_d = drop_cnt_q + {31'd0, drop};
  end

  always_comb begin
    key_d       = key_q;
    ts4_d       = ts4_q;
    t1_d        = t1_q;
    t2_d        = t2_q;
    t4_d        = t4_q;
    type_d      = type_q;
    key_vld_d   = 1'b0;
    sync_vld_d  = 1'b0;
    dresp_vld_d = 1'b0;
    type_vld_d  = 1'b0;
    if (accept) begin
      type_vld_d = 1'b1;
      type_d     = msg_to_rx_type(lat_msg);
      case (lat_msg)
        MSG_SYNC: begin
          sync_vld_d = 1'b1;
          t1_d       = lat_tail;
          t2_d       = lat_ts;
        end
        MSG_DREQ: begin
          key_vld_d = 1'b1;
          key_d     = {lat_smac, lat_port};
          ts4_d     = lat_ts;
        end
        MSG_DRESP: begin
          dresp_vld_d = 1'b1;
          t4_d        = lat_tail;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      seen_tail_q <= 1'b0;
      ptp_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      key_q       <= '0;
      ts4_q       <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      t4_q        <= '0;
      type_q      <= '0;
      key_vld_q   <= 1'b0;
      sync_vld_q  <= 1'b0;
      dresp_vld_q <= 1'b0;
      type_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      seen_tail_q <= seen_tail_d;
      ptp_cnt_q   <= ptp_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      key_q       <= key_d;
      ts4_q       <= ts4_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      t4_q        <= t4_d;
      type_q      <= type_d;
      key_vld_q   <= key_vld_d;
      sync_vld_q  <= sync_vld_d;
      dresp_vld_q <= dresp_vld_d;
      type_vld_q  <= type_vld_d;
    end
  end

  assign key               = key_q;
  assign key_valid         = key_vld_q;
  assign ts_4              = ts4_q;
  assign ts_4_valid        = key_vld_q;
  assign sync_t1           = t1_q;
  assign sync_t2           = t2_q;
  assign sync_valid        = sync_vld_q;
  assign dresp_t4          = t4_q;
  assign dresp_valid       = dresp_vld_q;
  assign ptp_rx_type       = type_q;
  assign ptp_rx_type_valid = type_vld_q;
  assign rx_ptp_cnt        = ptp_cnt_q;
  assign rx_drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_ptp_rx_parser.sv
// Scoreboard bench for ptp_rx_parser: directed frames plus randomized traffic
// judged by a frame-level accept/drop model.
module tb_ptp_rx_parser;
  import ptp_rx_parser_pkg::*;

  localparam logic [47:0] MAC = 48'h0200_1122_3344;
  localparam int PKT_WORDS = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_data_wr = 1'b0;
  logic [133:0] in_data = '0;
  logic         in_valid_wr = 1'b0;
  logic         in_valid = 1'b0;
  logic [53:0]  key;
  logic         key_valid, ts_4_valid, sync_valid, dresp_valid, ptp_rx_type_valid;
  logic [47:0]  ts_4, sync_t1, sync_t2, dresp_t4;
  logic [3:0]   ptp_rx_type;
  logic [31:0]  rx_ptp_cnt, rx_drop_cnt;

  always #5 clk = ~clk;

  ptp_rx_parser dut (
    .clk(clk), .rst_n(rst_n), .in_data_wr(in_data_wr), .in_data(in_data),
    .in_valid_wr(in_valid_wr), .in_valid(in_valid), .MAC_ADDR(MAC),
    .key(key), .key_valid(key_valid), .ts_4(ts_4), .ts_4_valid(ts_4_valid),
    .sync_t1(sync_t1), .sync_t2(sync_t2), .sync_valid(sync_valid),
    .dresp_t4(dresp_t4), .dresp_valid(dresp_valid),
    .ptp_rx_type(ptp_rx_type), .ptp_rx_type_valid(ptp_rx_type_valid),
    .rx_ptp_cnt(rx_ptp_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  // mode: 0 status with tail, 1 status dly cycles later, 2 status with next head, 3 none
  typedef struct {
    int n; bit has_tail; int mode; int dly; bit good;
    logic [5:0] port; logic [47:0] ts, dmac, smac, tail;
    logic [15:0] etype; logic [7:0] msgt, ver;
  } frame_t;

  typedef struct {
    logic [3:0] rt; logic [47:0] t1, t2, ts4, t4; logic [53:0] key;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0, n_err = 0;
  logic [31:0] m_ptp = 0, m_drop = 0;
  logic [47:0] m_t1 = 0, m_t2 = 0, m_ts4 = 0, m_t4 = 0;
  logic [53:0] m_key = 0;
  logic [3:0]  m_type = 0;
  bit          pend_vld = 0, pend_val = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit frame_ok(input frame_t f);
    if (!f.has_tail || f.mode == 3 || f.n != PKT_WORDS) return 0;
    if (f.etype != 16'h88F7 || f.ver != 8'h01) return 0;
    if (f.dmac != 48'hFFFF_FFFF_FFFF && f.dmac != MAC) return 0;
    if (!(f.msgt inside {8'h01, 8'h03, 8'h04, 8'h05})) return 0;
    return f.good;
  endfunction

  function automatic void model_frame(input frame_t f);
    exp_t e;
    if (!frame_ok(f)) begin
      m_drop++;
      return;
    end
    m_ptp++;
    m_type = f.msgt[3:0];
    if (f.msgt == 8'h01) begin m_t1 = f.tail; m_t2 = f.ts; end
    if (f.msgt == 8'h03) begin m_key = {f.smac, f.port}; m_ts4 = f.ts; end
    if (f.msgt == 8'h04) m_t4 = f.tail;
    e.rt = m_type; e.t1 = m_t1; e.t2 = m_t2; e.ts4 = m_ts4; e.t4 = m_t4; e.key = m_key;
    exp_q.push_back(e);
  endfunction

  function automatic frame_t mk_frame(input logic [7:0] msgt);
    frame_t f;
    f.n = PKT_WORDS; f.has_tail = 1; f.mode = 0; f.dly = 1; f.good = 1;
    f.port = 6'($urandom); f.ts = 48'({$urandom, $urandom});
    f.dmac = 48'hFFFF_FFFF_FFFF; f.smac = 48'({$urandom, $urandom});
    f.tail = 48'({$urandom, $urandom});
    f.etype = 16'h88F7; f.msgt = msgt; f.ver = 8'h01;
    return f;
  endfunction

  function automatic frame_t rand_frame(input bit last);
    frame_t f;
    logic [7:0] mt[8] = '{8'h01, 8'h03, 8'h04, 8'h05, 8'h01, 8'h03, 8'h02, 8'h00};
    f = mk_frame(mt[$urandom_range(0, 7)]);
    case ($urandom_range(0, 3))
      0: f.dmac = 48'hFFFF_FFFF_FFFF;
      1, 2: f.dmac = MAC;
      default: f.dmac = 48'({$urandom, $urandom}) & 48'h7FFF_FFFF_FFFF;
    endcase
    if ($urandom_range(0, 9) == 0) f.etype = 16'h0800;
    if ($urandom_range(0, 9) == 0) f.ver = 8'h02;
    if ($urandom_range(0, 7) == 0) f.n = $urandom_range(2, 9);
    f.has_tail = last || ($urandom_range(0, 11) != 0);
    f.good = ($urandom_range(0, 6) != 0);
    f.mode = last ? $urandom_range(0, 1) : $urandom_range(0, 3);
    if (!f.has_tail) f.mode = 3;
    f.dly = $urandom_range(1, 3);
    return f;
  endfunction

  function automatic logic [133:0] build_word(input frame_t f, input int i);
    logic [127:0] d;
    logic [1:0]   h;
    d = {$urandom, $urandom, $urandom, $urandom};
    h = (i == 0) ? HDR_HEAD : (f.has_tail && i == f.n - 1) ? HDR_TAIL : HDR_MID;
    if (i == 0) begin d[125:120] = f.port; d[47:0] = f.ts; end
    if (i == 2) begin
      d[127:80] = f.dmac; d[79:32] = f.smac; d[31:16] = f.etype;
      d[15:8] = f.msgt; d[7:0] = f.ver;
    end
    if (h == HDR_TAIL) d[95:48] = f.tail;
    return {h, 4'($urandom_range(1, 15)), d};
  endfunction

  task automatic drive_word(input logic [133:0] w, input logic vwr, input logic v);
    @(posedge clk); #1;
    in_data_wr = 1'b1; in_data = w; in_valid_wr = vwr; in_valid = v;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_data_wr = 1'b0; in_valid_wr = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f);
    logic [133:0] w;
    logic vwr, v;
    model_frame(f);
    for (int i = 0; i < f.n; i++) begin
      w = build_word(f, i);
      vwr = 1'b0; v = 1'b0;
      if (i == 0 && pend_vld) begin vwr = 1'b1; v = pend_val; pend_vld = 0; end
      if (w[133:132] == HDR_TAIL && f.mode == 0) begin vwr = 1'b1; v = f.good; end
      drive_word(w, vwr, v);
    end
    if (f.mode == 1) begin
      repeat (f.dly) idle();
      @(posedge clk); #1;
      in_data_wr = 1'b0; in_valid_wr = 1'b1; in_valid = f.good;
    end else if (f.mode == 2) begin
      pend_vld = 1; pend_val = f.good;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".ptp_cnt"}, rx_ptp_cnt, m_ptp);
    check({tag, ".drop_cnt"}, rx_drop_cnt, m_drop);
    check({tag, ".sync_t1"}, sync_t1, m_t1);
    check({tag, ".sync_t2"}, sync_t2, m_t2);
    check({tag, ".key"}, key, m_key);
    check({tag, ".ts_4"}, ts_4, m_ts4);
    check({tag, ".dresp_t4"}, dresp_t4, m_t4);
    check({tag, ".rx_type"}, ptp_rx_type, m_type);
    check({tag, ".pending"}, exp_q.size(), 0);
  endtask

  task automatic quiesce(input string tag);
    repeat (4) idle();
    check_state(tag);
  endtask

  // Monitor: every type pulse pops one expected accept; other pulses must follow it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ptp_rx_type_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_accept: got type %0d expected no pulse", ptp_rx_type);
        end else begin
          e = exp_q.pop_front();
          check("rx_type", ptp_rx_type, e.rt);
          check("sync_valid", sync_valid, e.rt == 4'd1);
          check("key_valid", key_valid, e.rt == 4'd3);
          check("ts_4_valid", ts_4_valid, e.rt == 4'd3);
          check("dresp_valid", dresp_valid, e.rt == 4'd4);
          if (e.rt == 4'd1) begin check("sync_t1", sync_t1, e.t1); check("sync_t2", sync_t2, e.t2); end
          if (e.rt == 4'd3) begin check("key", key, e.key); check("ts_4", ts_4, e.ts4); end
          if (e.rt == 4'd4) check("dresp_t4", dresp_t4, e.t4);
        end
      end else begin
        check("stray_pulse", {sync_valid, key_valid, ts_4_valid, dresp_valid}, 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t f, g;
    #2;
    check_state("reset");
    check("reset.type_valid", ptp_rx_type_valid, 0);
    @(negedge clk); rst_n = 1'b1;

    // Sync to broadcast
    f = mk_frame(MSG_SYNC);
    f.ts = 48'h0000_0001_0000; f.tail = 48'h0000_0000_1234;
    send_frame(f);
    quiesce("sync");
    check("plan.sync_t1", sync_t1, 48'h1234);
    check("plan.sync_t2", sync_t2, 48'h0000_0001_0000);
    check("plan.ptp_cnt1", rx_ptp_cnt, 32'd1);

    // Delay request addressed to the local MAC
    f = mk_frame(MSG_DREQ);
    f.port = 6'd2; f.smac = 48'h0A0B0C0D0E0F; f.dmac = MAC; f.ts = 48'h55;
    send_frame(f);
    quiesce("dreq");
    check("plan.key", key, {48'h0A0B0C0D0E0F, 6'd2});
    check("plan.ts_4", ts_4, 48'h55);

    // Non-PTP EtherType, then a foreign DMAC
    f = mk_frame(MSG_SYNC); f.etype = 16'h0800; f.mode = 1; f.dly = 2;
    send_frame(f);
    f = mk_frame(MSG_SYNC); f.dmac = 48'h0200_1122_3345;
    send_frame(f);
    quiesce("filter");
    check("plan.drop2", rx_drop_cnt, 32'd2);

    // Dresp with bad status, then a 5-word frame
    f = mk_frame(MSG_DRESP); f.good = 0;
    send_frame(f);
    f = mk_frame(MSG_DRESP); f.n = 5;
    send_frame(f);
    quiesce("bad_dresp");
    check("plan.drop4", rx_drop_cnt, 32'd4);

    // Back-to-back: second head shares a cycle with the first frame's status
    f = mk_frame(MSG_SYNC); f.mode = 2;
    g = mk_frame(MSG_DREQ); g.dmac = MAC;
    send_frame(f);
    send_frame(g);
    quiesce("b2b");
    check("plan.ptp_cnt4", rx_ptp_cnt, 32'd4);

    // Reset during w3 of a sync frame
    f = mk_frame(MSG_SYNC);
    for (int i = 0; i < 4; i++) drive_word(build_word(f, i), 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; in_data_wr = 1'b0; in_valid_wr = 1'b0;
    m_ptp = 0; m_drop = 0; m_t1 = 0; m_t2 = 0; m_ts4 = 0; m_t4 = 0; m_key = 0; m_type = 0;
    #1;
    check_state("in_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    f = mk_frame(MSG_SYNC);
    send_frame(f);
    quiesce("after_reset");
    check("plan.rst_cnt", rx_ptp_cnt, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 250; i++) send_frame(rand_frame(1'b0));
    send_frame(rand_frame(1'b1));
    quiesce("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
